picomips_ctrl: RTL and testbench

- Instruction decoder and sequencing controller for the picoMIPS core.
- Sits directly upstream of the program counter: consumes the instruction word from program memory and drives the PC control strobes and branch operand.
- Also drives register-file write enable and ALU controls.
- Holds the zero flag, a wait-for-switch handshake FSM and a halt state.

---
 rtl/picomips_ctrl.sv | 157 +++++++++++++++
 tb/tb_picomips_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/picomips_ctrl.sv
// picomips_ctrl: instruction decoder and sequencing controller for picoMIPS.
// Decodes the current instruction and drives the PC strobes, the branch operand,
// the register-file write enable and the ALU controls. It holds the zero flag,
// a two-flop switch synchroniser and a RUN / WAIT_PRESS / WAIT_RELEASE / HALT state.
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   instr              instruction word; opcode is in the top 4 bits
//   alu_zero           ALU result-is-zero, valid in the same cycle as instr
//   sw                 asynchronous user switch
//   PCincr/PCabsbranch/PCrelbranch  PC strobes, at most one high
//   Branchaddr         low Psize bits of instr (absolute target or offset)
//   w, imm, alu_op     register-file write, immediate select, ALU function
//   halted, illegal    HALT state flag, undefined-opcode flag
// Outputs are combinational so the PC acts on them at the next edge.
module picomips_ctrl #(
    parameter int unsigned Psize = 5,
    parameter int unsigned Isize = 20
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [Isize-1:0] instr,
    input  logic             alu_zero,
    input  logic             sw,
    output logic             PCincr,
    output logic             PCabsbranch,
    output logic             PCrelbranch,
    output logic [Psize-1:0] Branchaddr,
    output logic             w,
    output logic             imm,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             illegal
);

    localparam int unsigned OpW = 4;

    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluSub  = 2'b01;
    localparam logic [1:0] AluMul  = 2'b10;
    localparam logic [1:0] AluPass = 2'b11;

    typedef enum logic [1:0] {
        S_RUN          = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_HALT         = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_zf;
    logic             w_zf_load;
    logic             r_sw_meta;
    logic             r_sw_s;
    logic [OpW-1:0]   w_op;
    logic             w_unused_instr;

    assign w_op           = instr[Isize-1 -: OpW];
    // Middle instruction bits are the datapath's business, not the controller's.
    assign w_unused_instr = ^instr;

    // State, zero flag and switch synchroniser.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_RUN;
            r_zf      <= 1'b0;
            r_sw_meta <= 1'b0;
            r_sw_s    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sw_meta <= sw;
            r_sw_s    <= r_sw_meta;
            if (w_zf_load) begin
                r_zf <= alu_zero;
            end
        end
    end

    // Decode and next-state logic; everything forced low while in reset.
    always_comb begin
        PCincr      = 1'b0;
        PCabsbranch = 1'b0;
        PCrelbranch = 1'b0;
        Branchaddr  = instr[Psize-1:0];
        w           = 1'b0;
        imm         = 1'b0;
        alu_op      = AluAdd;
        halted      = 1'b0;
        illegal     = 1'b0;
        w_zf_load   = 1'b0;
        w_state_nxt = r_state;

        unique case (r_state)
            S_RUN: begin
                case (w_op)
                    4'h0: PCincr = 1'b1;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                        PCincr    = 1'b1;
                        w         = 1'b1;
                        w_zf_load = 1'b1;
                        imm       = (w_op == 4'h2) || (w_op == 4'h4) || (w_op == 4'h6);
                        if (w_op == 4'h1 || w_op == 4'h2)      alu_op = AluAdd;
                        else if (w_op == 4'h3 || w_op == 4'h4) alu_op = AluSub;
                        else                                    alu_op = AluMul;
                    end
                    4'h7: begin
                        PCrelbranch = r_zf;
                        PCincr      = ~r_zf;
                    end
                    4'h8: begin
                        PCrelbranch = ~r_zf;
                        PCincr      = r_zf;
                    end
                    4'h9: PCabsbranch = 1'b1;
                    4'hA: w_state_nxt = S_WAIT_PRESS;
                    4'hB: begin
                        PCincr = 1'b1;
                        w      = 1'b1;
                        imm    = 1'b1;
                        alu_op = AluPass;
                    end
                    4'hC: w_state_nxt = S_HALT;
                    default: begin
                        PCincr  = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_WAIT_PRESS: begin
                if (r_sw_s) w_state_nxt = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                // Advance the PC exactly once, on the release.
                if (!r_sw_s) begin
                    PCincr      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_state_nxt = S_RUN;
        endcase

        if (!nreset) begin
            PCincr      = 1'b0;
            PCabsbranch = 1'b0;
            PCrelbranch = 1'b0;
            Branchaddr  = '0;
            w           = 1'b0;
            imm         = 1'b0;
            alu_op      = AluAdd;
            halted      = 1'b0;
            illegal     = 1'b0;
            w_zf_load   = 1'b0;
        end
    end

endmodule

// File: tb/tb_picomips_ctrl.sv
// tb_picomips_ctrl: directed scenarios plus randomized instruction streams,
// checked every cycle against a behavioural model of the controller.
module tb_picomips_ctrl;

    localparam int unsigned Psize = 5;
    localparam int unsigned Isize = 20;

    logic             clk;
    logic             nreset;
    logic [Isize-1:0] instr;
    logic             alu_zero;
    logic             sw;
    logic             PCincr;
    logic             PCabsbranch;
    logic             PCrelbranch;
    logic [Psize-1:0] Branchaddr;
    logic             w;
    logic             imm;
    logic [1:0]       alu_op;
    logic             halted;
    logic             illegal;

    int n_cmp;
    int n_err;

    // Model state: 0 running, 1 waiting for press, 2 waiting for release, 3 stopped.
    int m_mode;
    bit m_zf;
    bit m_swq[$];

    picomips_ctrl #(.Psize(Psize), .Isize(Isize)) dut (
        .clk(clk), .nreset(nreset), .instr(instr), .alu_zero(alu_zero), .sw(sw),
        .PCincr(PCincr), .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch),
        .Branchaddr(Branchaddr), .w(w), .imm(imm), .alu_op(alu_op),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] dut_bundle();
        return {PCincr, PCabsbranch, PCrelbranch, Branchaddr, w, imm, alu_op, halted, illegal};
    endfunction

    function automatic bit model_sws();
        return (m_swq.size() >= 2) ? m_swq[1] : 1'b0;
    endfunction

    // Expected outputs from the instruction-set rules.
    function automatic logic [14:0] model_out(input logic [3:0] op, input logic [4:0] lo);
        bit inc, ab, rel, wr, im, hlt, ill;
        logic [1:0] fn;
        int opi;
        inc = 0; ab = 0; rel = 0; wr = 0; im = 0; hlt = 0; ill = 0; fn = 2'b00;
        opi = int'(op);
        if (m_mode == 0) begin
            if (opi == 0) inc = 1;
            else if (opi >= 1 && opi <= 6) begin
                inc = 1; wr = 1;
                im  = (opi % 2 == 0);
                fn  = 2'((opi - 1) / 2);
            end
            else if (opi == 7) begin rel = m_zf;  inc = !m_zf; end
            else if (opi == 8) begin rel = !m_zf; inc = m_zf;  end
            else if (opi == 9) ab = 1;
            else if (opi == 11) begin inc = 1; wr = 1; im = 1; fn = 2'b11; end
            else if (opi >= 13) begin inc = 1; ill = 1; end
        end
        else if (m_mode == 2) inc = !model_sws();
        else if (m_mode == 3) hlt = 1;
        return {inc, ab, rel, lo, wr, im, fn, hlt, ill};
    endfunction

    function automatic logic [Isize-1:0] mk_instr(input logic [3:0] op, input logic [4:0] lo);
        logic [10:0] mid;
        mid = 11'($urandom);
        return {op, mid, lo};
    endfunction

    // One clock cycle: drive, compare mid-cycle, advance the model at the edge.
    task automatic run_cycle(input string tag, input logic [3:0] op, input logic [4:0] lo,
                             input logic az, input logic s);
        logic [14:0] exp;
        int strobes;
        instr    = mk_instr(op, lo);
        alu_zero = az;
        sw       = s;
        #3;
        exp = nreset ? model_out(op, lo) : 15'd0;
        check(tag, 32'(dut_bundle()), 32'(exp));
        strobes = int'(PCincr) + int'(PCabsbranch) + int'(PCrelbranch);
        check({tag, "_one_strobe"}, 32'(strobes > 1), 32'd0);
        @(posedge clk);
        if (nreset) begin
            if (m_mode == 0) begin
                if (op == 4'hA) m_mode = 1;
                else if (op == 4'hC) m_mode = 3;
                else if (op >= 4'h1 && op <= 4'h6) m_zf = az;
            end
            else if (m_mode == 1) begin
                if (model_sws()) m_mode = 2;
            end
            else if (m_mode == 2) begin
                if (!model_sws()) m_mode = 0;
            end
            m_swq.push_front(s);
            if (m_swq.size() > 2) void'(m_swq.pop_back());
        end
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, held two cycles, released off-edge.
    task automatic do_reset(input string tag);
        instr  = mk_instr(4'($urandom), 5'($urandom));
        nreset = 1'b0;
        #1;
        check({tag, "_async"}, 32'(dut_bundle()), 32'd0);
        m_mode = 0;
        m_zf   = 0;
        m_swq.delete();
        @(posedge clk);
        #1;
        run_cycle({tag, "_hold"}, 4'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        run_cycle({tag, "_hold"}, 4'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        nreset = 1'b1;
    endtask

    initial begin
        logic [3:0] op;
        logic       s;
        n_cmp    = 0;
        n_err    = 0;
        m_mode   = 0;
        m_zf     = 0;
        nreset   = 1'b0;
        instr    = '0;
        alu_zero = 1'b0;
        sw       = 1'b0;
        #2;
        check("reset_state", 32'(dut_bundle()), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // NOP stream, then a mid-stream reset.
        for (int i = 0; i < 3; i++) run_cycle("nop", 4'h0, 5'($urandom), 1'($urandom), 1'b0);
        #1;
        do_reset("rst_mid");

        // SUB sets zf, BEQ takes the relative branch to offset 30.
        run_cycle("sub", 4'h3, 5'($urandom), 1'b1, 1'b0);
        run_cycle("beq_taken", 4'h7, 5'b11110, 1'($urandom), 1'b0);

        // ADDI clears zf; a NOP with alu_zero=1 must not disturb it.
        run_cycle("addi", 4'h2, 5'($urandom), 1'b0, 1'b0);
        run_cycle("bne_taken", 4'h8, 5'($urandom), 1'b1, 1'b0);
        run_cycle("nop_az", 4'h0, 5'($urandom), 1'b1, 1'b0);
        run_cycle("bne_again", 4'h8, 5'($urandom), 1'b1, 1'b0);

        // Switch handshake: one PC advance per press/release.
        run_cycle("waitsw", 4'hA, 5'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle("wait_idle", 4'($urandom), 5'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle("wait_press", 4'($urandom), 5'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) run_cycle("wait_release", 4'h0, 5'($urandom), 1'b0, 1'b0);
        run_cycle("resume", 4'h1, 5'($urandom), 1'b0, 1'b0);

        // JMP, then HALT ignores instructions until reset.
        run_cycle("jmp", 4'h9, 5'd7, 1'b0, 1'b0);
        run_cycle("halt", 4'hC, 5'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) run_cycle("halted", 4'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        do_reset("rst_halt");
        run_cycle("after_halt", 4'h0, 5'($urandom), 1'b0, 1'b0);

        // Undefined opcode; WAITSW with the switch already held.
        run_cycle("illegal", 4'hE, 5'($urandom), 1'b0, 1'b1);
        run_cycle("pre_held", 4'h0, 5'($urandom), 1'b0, 1'b1);
        run_cycle("waitsw_held", 4'hA, 5'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle("held", 4'($urandom), 5'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) run_cycle("held_release", 4'h0, 5'($urandom), 1'b0, 1'b0);

        // Randomized streams with slowly changing switch and occasional resets.
        s = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset("rst_rand");
            op = 4'($urandom);
            if (op == 4'hC && $urandom_range(0, 3) != 0) op = 4'h0;
            if ($urandom_range(0, 5) == 0) s = ~s;
            run_cycle("rand", op, 5'($urandom), 1'($urandom), s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
